// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot sequencer and the CPU top.
package imem_boot_ctrl_pkg;

    localparam int DEF_ABITS = 32;
    localparam int DEF_DBITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } boot_state_e;

endpackage

// File: rtl/boot_down_counter.sv
// Loadable down counter with zero flag; times how long the CPU stays in reset after a load.
module boot_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load wins over decrement; decrement stops at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/reload sequencer: holds the CPU in reset, streams a program into
// instruction memory, then releases the CPU after a fixed hold time.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int ABITS     = DEF_ABITS,
    parameter int DBITS     = DEF_DBITS,
    parameter int MAX_WORDS = 1024,
    parameter int LW        = 11,
    parameter int RST_HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DBITS-1:0] s_data,
    output logic             imem_sel,
    output logic             imem_en,
    output logic             imem_we,
    output logic [ABITS-1:0] imem_addr,
    output logic [DBITS-1:0] imem_din,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Hold counter must represent RST_HOLD-1
    localparam int          HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);
    localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_WORDS);

    boot_state_e      state_r;
    boot_state_e      state_nxt_s;
    logic [LW-1:0]    len_r;
    logic [LW-1:0]    cnt_r;
    logic             err_r;

    logic             len_ok_s;
    logic             accept_s;
    logic             reject_s;
    logic             xfer_s;
    logic             hold_load_s;
    logic             hold_dec_s;
    logic             hold_zero_s;
    logic             ready_s;
    logic             ldr_sel_s;
    logic             cpu_rst_s;
    logic             busy_s;
    logic             done_s;
    logic             ldr_en_s;
    logic             ldr_we_s;
    logic [ABITS-1:0] ldr_addr_s;
    logic [DBITS-1:0] ldr_din_s;

    assign len_ok_s = (len != {LW{1'b0}}) && (len <= MAX_LEN);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and state-decoded controls
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        xfer_s      = 1'b0;
        hold_load_s = 1'b0;
        hold_dec_s  = 1'b0;
        ready_s     = 1'b0;
        ldr_sel_s   = 1'b1;
        cpu_rst_s   = 1'b1;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end else begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
                xfer_s  = s_valid;
                if (s_valid && (cnt_r == (len_r - LW'(1)))) begin
                    hold_load_s = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                busy_s = 1'b1;
                if (hold_zero_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    hold_dec_s  = 1'b1;
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                done_s    = 1'b1;
                cpu_rst_s = 1'b0;
                ldr_sel_s = 1'b0;
                // An invalid reload request leaves the running CPU untouched
                if (start) begin
                    if (len_ok_s) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end else begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latched length and word counter; bounded by len_r so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r <= {LW{1'b0}};
            cnt_r <= {LW{1'b0}};
        end else if (accept_s) begin
            len_r <= len;
            cnt_r <= {LW{1'b0}};
        end else if (xfer_s) begin
            len_r <= len_r;
            cnt_r <= cnt_r + LW'(1);
        end else begin
            len_r <= len_r;
            cnt_r <= cnt_r;
        end
    end

    // Rejected-start flag, a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= reject_s;
        end
    end

    boot_down_counter #(
        .W (HW)
    ) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load_s),
        .load_val (HOLD_INIT),
        .dec      (hold_dec_s),
        .zero     (hold_zero_s)
    );

    assign ldr_en_s   = xfer_s;
    assign ldr_we_s   = xfer_s;
    assign ldr_addr_s = xfer_s ? ABITS'(cnt_r) : {ABITS{1'b0}};
    assign ldr_din_s  = xfer_s ? s_data : {DBITS{1'b0}};

    // Loader side of the imem port mux; the fetch path takes over when imem_sel=0
    assign imem_sel  = ldr_sel_s;
    assign imem_en   = ldr_sel_s ? ldr_en_s   : 1'b0;
    assign imem_we   = ldr_sel_s ? ldr_we_s   : 1'b0;
    assign imem_addr = ldr_sel_s ? ldr_addr_s : {ABITS{1'b0}};
    assign imem_din  = ldr_sel_s ? ldr_din_s  : {DBITS{1'b0}};

    assign s_ready   = ready_s;
    assign cpu_reset = cpu_rst_s | reset;
    assign busy      = busy_s;
    assign done      = done_s;
    assign err       = err_r;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: random program loads checked
// against a word-count/phase model and a captured memory image.
module tb_imem_boot_ctrl;

    localparam int ABITS     = 32;
    localparam int DBITS     = 32;
    localparam int MAX_WORDS = 1024;
    localparam int LW        = 11;
    localparam int RST_HOLD  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LW-1:0]    len;
    logic             s_valid;
    logic             s_ready;
    logic [DBITS-1:0] s_data;
    logic             imem_sel;
    logic             imem_en;
    logic             imem_we;
    logic [ABITS-1:0] imem_addr;
    logic [DBITS-1:0] imem_din;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int bad_wr = 0;
    logic [DBITS-1:0] cap_mem [0:MAX_WORDS-1];
    logic [DBITS-1:0] ref_mem [0:MAX_WORDS-1];

    always #5 clk = ~clk;

    imem_boot_ctrl #(
        .ABITS(ABITS), .DBITS(DBITS), .MAX_WORDS(MAX_WORDS), .LW(LW), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_sel(imem_sel), .imem_en(imem_en), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_din(imem_din),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    // Behavioural instruction memory: records every write the loader performs
    always @(posedge clk) begin
        if (imem_en && imem_we) begin
            cap_mem[imem_addr[9:0]] <= imem_din;
            wr_count <= wr_count + 1;
            if (!s_valid || !imem_sel || (imem_addr >= MAX_WORDS)) bad_wr <= bad_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs expected while idle (in_run=0) or running (in_run=1) with no load
    task automatic chk_quiet(input string tag, input bit in_run);
        chk({tag, "_done"}, done, in_run);
        chk({tag, "_cpu_reset"}, cpu_reset, !in_run);
        chk({tag, "_sel"}, imem_sel, !in_run);
        chk({tag, "_ready"}, s_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // pat: 0 continuous valid, 1 toggling valid, 2 random valid
    task automatic run_load(input int n, input int pat, input bit fixed, input bit poke);
        int sent = 0;
        int held = 0;
        int k = 0;
        int wr0;
        int bad_mem = 0;
        int budget;
        wr0 = wr_count;
        budget = 8 * n + 4 * RST_HOLD + 20;
        start = 1'b1;
        len = LW'(n);
        s_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        while (sent < n || held < RST_HOLD) begin
            if (k >= budget) break;
            if (pat == 0) s_valid = 1'b1;
            else if (pat == 1) s_valid = ((k % 2) == 0);
            else s_valid = ($urandom_range(99) >= 40);
            s_data = fixed ? (32'hA0000001 + DBITS'(sent)) : DBITS'($urandom);
            if (poke && ($urandom_range(3) == 0)) begin
                start = 1'b1;
                len = LW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (sent < n) begin
                chk("load_ready", s_ready, 1);
                chk("load_cpu_reset", cpu_reset, 1);
                chk("load_sel", imem_sel, 1);
                chk("load_busy", busy, 1);
                chk("load_we", imem_we, s_valid);
                if (s_valid) begin
                    chk("load_addr", imem_addr, sent);
                    chk("load_din", imem_din, s_data);
                    ref_mem[sent] = s_data;
                    sent++;
                end
            end else begin
                chk("hold_ready", s_ready, 0);
                chk("hold_we", imem_we, 0);
                chk("hold_cpu_reset", cpu_reset, 1);
                chk("hold_busy", busy, 1);
                chk("hold_done", done, 0);
                held++;
            end
            chk("load_err", err, 0);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (k >= budget) chk("load_timeout", 1, 0);
        @(negedge clk);
        chk_quiet("run", 1'b1);
        chk("run_en", imem_en, 0);
        chk("run_err", err, 0);
        if (pat == 0) chk("min_latency", k, n + RST_HOLD);
        chk("write_count", wr_count - wr0, n);
        chk("stray_writes", bad_wr, 0);
        for (int i = 0; i < n; i++) begin
            if (cap_mem[i] !== ref_mem[i]) bad_mem++;
        end
        chk("mem_contents", bad_mem, 0);
        @(posedge clk); #1;
    endtask

    task automatic try_bad(input int l, input bit in_run);
        start = 1'b1;
        len = LW'(l);
        s_valid = 1'b0;
        @(negedge clk);
        chk("bad_err_early", err, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("bad_err_pulse", err, 1);
        chk_quiet("bad", in_run);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_err_clear", err, 0);
        chk_quiet("bad_after", in_run);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len = '0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset", 1'b0);
        chk("reset_en", imem_en, 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        try_bad(0, 1'b0);
        try_bad(MAX_WORDS + 1, 1'b0);
        try_bad(2047, 1'b0);

        run_load(3, 0, 1'b1, 1'b0);
        run_load(4, 1, 1'b0, 1'b1);
        try_bad(0, 1'b1);
        try_bad(MAX_WORDS + 1, 1'b1);
        run_load(2, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            run_load($urandom_range(40, 1), $urandom_range(2, 0), 1'b0, 1'(r % 2));
        end

        // Asynchronous reset after 2 of 5 words
        start = 1'b1;
        len = LW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = DBITS'($urandom);
            @(posedge clk); #1;
        end
        chk("preload_we", imem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_quiet("midreset", 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        s_valid = 1'b0;
        run_load(5, 2, 1'b0, 1'b0);

        run_load(MAX_WORDS, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
